// File: rtl/seq_mul_shift_add.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Fixed latency: WIDTH add/shift steps per product, independent of operand values.
// Signed mode multiplies magnitudes and negates the result afterwards.
//
// Handshake:
//   - start is accepted on a rising edge while the FSM is IDLE or DONE.
//   - busy is high for the WIDTH CALC cycles.
//   - done pulses for one cycle, while product is valid.
//   - start during CALC is ignored.
//   - product holds its value until the next DONE.
//
// dbg_state shows the FSM state: 0 = IDLE, 1 = CALC, 2 = DONE.
// WIDTH must lie in 2..32.
module seq_mul_shift_add #(
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
   localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);

   state_t               r_state;
   state_t               w_next;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_product;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;

   logic                 w_accept;
   logic                 w_last;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_sum;
   logic [2*WIDTH-1:0]   w_prod_final;

   // A new request is taken only when no multiply is in flight.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // The final step is the CALC cycle whose counter still reads 1.
   assign w_last = (r_state == S_CALC) && (r_cnt == ONE_C);

   // In signed mode a negative operand is replaced by its magnitude.
   // The most negative value maps onto 2^(WIDTH-1), which fits as unsigned.
   assign w_a_mag = (sgn && a_in[WIDTH-1]) ? (~a_in + ONE_W) : a_in;
   assign w_b_mag = (sgn && b_in[WIDTH-1]) ? (~b_in + ONE_W) : b_in;

   // Conditional add of the shifted multiplicand.
   // The accumulator is 2*WIDTH bits wide, so the sum cannot overflow.
   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_sum = r_acc + w_addend;

   // Restore the sign on the completed sum.
   assign w_prod_final = r_neg ? (~w_acc_sum + ONE_2W) : w_acc_sum;

   // State register; reset wins over everything, including a multiply in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and the status outputs.
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_CALC;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (r_cnt == ONE_C) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               w_next = S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, one add/shift step per CALC cycle, and the
   // product load on the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
      end else if (w_accept) begin
         r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplier <= w_b_mag;
         r_neg    <= sgn && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
         r_acc    <= '0;
         r_cnt    <= CNT_W'(WIDTH);
      end else if (r_state == S_CALC) begin
         r_acc    <= w_acc_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - ONE_C;
         if (w_last) begin
            r_product <= w_prod_final;
         end
      end
   end

   assign product   = r_product;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Directed and random bench for seq_mul_shift_add.
// Three instances are exercised: WIDTH = 16, 8 and 4.
// Expected products come from signed/unsigned integer multiplication.
module tb_seq_mul_shift_add;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  st;
   logic [2:0]  sg;
   logic [2:0]  dn;
   logic [2:0]  bz;
   logic [15:0] a16, b16;
   logic [7:0]  a8, b8;
   logic [3:0]  a4, b4;
   logic [31:0] prod16;
   logic [15:0] prod8;
   logic [7:0]  prod4;
   logic [1:0]  dbg16, dbg8, dbg4;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] prev [3];

   always #5 clk = ~clk;

   seq_mul_shift_add #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .start(st[0]), .sgn(sg[0]), .a_in(a16), .b_in(b16),
      .busy(bz[0]), .done(dn[0]), .product(prod16), .dbg_state(dbg16)
   );
   seq_mul_shift_add #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(st[1]), .sgn(sg[1]), .a_in(a8), .b_in(b8),
      .busy(bz[1]), .done(dn[1]), .product(prod8), .dbg_state(dbg8)
   );
   seq_mul_shift_add #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(st[2]), .sgn(sg[2]), .a_in(a4), .b_in(b4),
      .busy(bz[2]), .done(dn[2]), .product(prod4), .dbg_state(dbg4)
   );

   function automatic int wid(int sel);
      return (sel == 0) ? 16 : ((sel == 1) ? 8 : 4);
   endfunction

   function automatic logic [63:0] prod_of(int sel);
      case (sel)
         0:       return {32'b0, prod16};
         1:       return {48'b0, prod8};
         default: return {56'b0, prod4};
      endcase
   endfunction

   // Reference: integer product of the w-bit operands, truncated to 2*w bits.
   function automatic logic [63:0] ref_mul(int w, logic [31:0] a, logic [31:0] b, logic s);
      logic [31:0] am, bm;
      longint      sa, sb, p;
      logic [63:0] mask;
      am   = a & ((32'd1 << w) - 32'd1);
      bm   = b & ((32'd1 << w) - 32'd1);
      sa   = longint'(am);
      sb   = longint'(bm);
      if (s && am[w-1]) sa = sa - (longint'(1) << w);
      if (s && bm[w-1]) sb = sb - (longint'(1) << w);
      p    = sa * sb;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(int sel, logic [31:0] a, logic [31:0] b, logic s);
      case (sel)
         0:       begin a16 = a[15:0]; b16 = b[15:0]; end
         1:       begin a8  = a[7:0];  b8  = b[7:0];  end
         default: begin a4  = a[3:0];  b4  = b[3:0];  end
      endcase
      sg[sel] = s;
   endtask

   // Present a request for one edge, then scramble the don't-care inputs.
   task automatic launch(int sel, logic [31:0] a, logic [31:0] b, logic s);
      set_in(sel, a, b, s);
      st[sel] = 1'b1;
      tick();
      st[sel] = 1'b0;
      set_in(sel, $urandom, $urandom, 1'($urandom_range(0, 1)));
   endtask

   // One full multiply. lat counts edges from presenting start up to the
   // edge after which done is seen; the accepting edge counts as edge 1.
   // With junk=1, start is held high with random operands during CALC;
   // it must be ignored.
   task automatic run_op(int sel, string tag, logic [31:0] a, logic [31:0] b,
                         logic s, bit junk, bit idle_after);
      logic [63:0] exp;
      int          lat;
      int          busy_cnt;
      bit          held_ok;
      exp      = ref_mul(wid(sel), a, b, s);
      launch(sel, a, b, s);
      lat      = 1;
      busy_cnt = 0;
      held_ok  = 1'b1;
      while (!dn[sel] && lat < 200) begin
         if (bz[sel]) busy_cnt++;
         if (prod_of(sel) !== prev[sel]) held_ok = 1'b0;
         if (junk && lat < wid(sel) - 4) begin
            st[sel] = 1'b1;
            set_in(sel, $urandom, $urandom, 1'($urandom_range(0, 1)));
         end else begin
            st[sel] = 1'b0;
         end
         tick();
         lat++;
      end
      check($sformatf("%s_latency", tag), 64'(lat), 64'(wid(sel) + 1));
      check($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), 64'(wid(sel)));
      check($sformatf("%s_held_in_calc", tag), 64'(held_ok), 64'd1);
      check($sformatf("%s_product", tag), prod_of(sel), exp);
      prev[sel] = exp;
      if (idle_after) begin
         tick();
         check($sformatf("%s_done_pulse", tag), {62'b0, dn[sel], bz[sel]}, 64'd0);
         check($sformatf("%s_product_held", tag), prod_of(sel), exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      st  = '0;
      sg  = '0;
      a16 = '0; b16 = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      for (int i = 0; i < 3; i++) prev[i] = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state of every instance.
      check("reset_w16", {30'b0, prod16, dn[0], bz[0]}, 64'd0);
      check("reset_w8",  {46'b0, prod8,  dn[1], bz[1]}, 64'd0);
      check("reset_w4",  {54'b0, prod4,  dn[2], bz[2]}, 64'd0);
      tick();

      // Directed WIDTH=16 cases.
      run_op(0, "u17x5",      32'd17,     32'd5,      1'b0, 1'b0, 1'b1);
      run_op(0, "s_m3x7",     32'hFFFD,   32'd7,      1'b1, 1'b0, 1'b1);
      run_op(0, "s_min_sq",   32'h8000,   32'h8000,   1'b1, 1'b0, 1'b1);
      run_op(0, "u_max_sq",   32'hFFFF,   32'hFFFF,   1'b0, 1'b0, 1'b1);
      run_op(0, "u_zero",     32'd0,      32'h1234,   1'b0, 1'b0, 1'b1);
      run_op(0, "s_m1xm1",    32'hFFFF,   32'hFFFF,   1'b1, 1'b0, 1'b1);

      // Start held during CALC is ignored; start in the DONE cycle is taken.
      run_op(0, "ign_4x5",    32'd4,      32'd5,      1'b0, 1'b1, 1'b0);
      run_op(0, "b2b_6x7",    32'd6,      32'd7,      1'b0, 1'b0, 1'b1);

      // Reset while the eighth CALC cycle is in progress discards the multiply.
      launch(0, 32'h1234, 32'h5678, 1'b0);
      repeat (7) tick();
      check("pre_rst_busy", {63'b0, bz[0]}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_state", {30'b0, prod16, dn[0], bz[0]}, 64'd0);
      for (int i = 0; i < 3; i++) prev[i] = '0;
      run_op(0, "post_rst_9x9", 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);

      // Narrower instances.
      run_op(1, "w8_s_min_sq", 32'h80, 32'h80, 1'b1, 1'b0, 1'b1);
      run_op(2, "w4_u_max_sq", 32'hF,  32'hF,  1'b0, 1'b0, 1'b1);
      run_op(2, "w4_s_min_sq", 32'h8,  32'h8,  1'b1, 1'b0, 1'b1);

      // Random operands, random mode, random back-to-back or idle spacing.
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = (n < 30) ? 0 : ((n < 45) ? 1 : 2);
         run_op(sel, $sformatf("rand%0d_w%0d", n, wid(sel)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      end
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
